seven_seg_scan_driver: RTL and testbench
========================================

// Module: seven_seg_scan_driver
// PURPOSE
//  Downstream of the two-digit binary-to-BCD/7-seg decoder stage; consumes its right/left 7-bit segment patterns.
//  Time-multiplexes both digits onto one shared segment bus with one-hot digit enables and a dead-time blank between digits.
//  Double-buffered: new patterns are applied only at a frame boundary, so a frame never shows mixed old/new digits.
//  Optional leading-zero blanking of the left digit.
// PARAMETERS
//  REFRESH_DIV   50000  clock cycles per digit slot (blank + show); legal range >= 2
//  BLANK_CYCLES  16     dead-time cycles at the start of each slot; legal range 1 .. REFRESH_DIV-1
//  COMMON_ANODE  0      1 = invert seg_out and dig_en at the output register (active-low pins)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  load       in   1  1-cycle strobe: capture seg_right/seg_left into the pending buffer
//  seg_right  in   7  right-digit pattern, bit0=a .. bit6=g, active-high
//  seg_left   in   7  left-digit pattern, same encoding
//  lz_blank   in   1  1 = suppress left digit when its active pattern == 7'b0111111 ("0")
//  seg_out    out  7  shared segment bus, registered
//  dig_en     out  2  digit enables, registered; bit0=right, bit1=left; one-hot or zero
//  frame_done out  1  1-cycle pulse at each frame boundary
// BEHAVIOUR
//  - Reset: state=BLANK_R, slot counter=0, active/pending buffers=0, pending_valid=0, frame_done=0.
//    seg_out=7'h00 and dig_en=2'b00; both are bitwise inverted when COMMON_ANODE=1.
//  - FSM: BLANK_R -> SHOW_R -> BLANK_L -> SHOW_L -> BLANK_R.
//    Each BLANK state lasts BLANK_CYCLES cycles; each SHOW state lasts REFRESH_DIV-BLANK_CYCLES cycles.
//    One frame = 2*REFRESH_DIV cycles.
//  - Slot counter has width $clog2(REFRESH_DIV) and runs 0..REFRESH_DIV-1.
//    It wraps to 0 at the end of each slot. The BLANK->SHOW transition occurs at count == BLANK_CYCLES-1.
//  - Outputs are registered and lag the state by exactly 1 cycle:
//    BLANK_*: dig_en=00, seg_out=0.
//    SHOW_R:  dig_en=01, seg_out=active_right.
//    SHOW_L:  dig_en=10, seg_out=active_left; if lz_blank=1 and active_left==7'b0111111, dig_en=00 and seg_out=0.
//    lz_blank is sampled every cycle, with no buffering.
//  - load=1: pending <= {seg_left,seg_right}, pending_valid <= 1. The last load within a frame wins.
//  - Frame boundary = the SHOW_L->BLANK_R transition cycle. If pending_valid: active <= pending, pending_valid <= 0.
//    frame_done is asserted on the same cycle as the output update of the boundary.
//  - load on the boundary cycle: the boundary copies the previous pending contents. The new data is stored
//    pending and applied at the next boundary.
//  - No load in a frame: the active buffer holds its value and the display repeats.
//  - rst mid-frame: immediate return to the reset state on the next edge. Pending data is discarded;
//    the display is blank until the first load completes a frame boundary.
//  - Enable glitch-freedom: dig_en never changes between two non-zero values on consecutive cycles
//    (a blank of >= BLANK_CYCLES cycles always intervenes).
// TESTING  (REFRESH_DIV=8, BLANK_CYCLES=2, COMMON_ANODE=0 unless noted)
//  1 Reset release -> dig_en=00, seg_out=0 for the whole first frame (16 cycles); frame_done pulses at cycle 16.
//  2 load with R=7'b0000110 ("1"), L=7'b1011011 ("2") mid-frame -> next frame: 2 cycles 00, 6 cycles
//    dig_en=01/seg=06h, 2 cycles 00, 6 cycles dig_en=10/seg=5Bh; repeats.
//  3 Two loads in one frame (first "3"/"4", then "5"/"6") -> only "5"/"6" is displayed; "3"/"4" never appears.
//  4 load asserted on the boundary cycle -> old digits are shown for one more frame; new digits from the following frame.
//  5 L=7'b0111111, R="7", lz_blank=1 -> the left slot shows dig_en=00; with lz_blank=0 -> dig_en=10, seg=3Fh.
//  6 COMMON_ANODE=1, rst asserted during SHOW_L -> next cycle seg_out=7Fh, dig_en=11; blank until the next load plus boundary.

Source files
------------

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: two-digit multiplexed 7-seg scanner with dead-time
// blanking, frame-boundary double buffering and left-digit zero blanking.
module seven_seg_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit COMMON_ANODE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] seg_right,
  input  logic [6:0] seg_left,
  input  logic       lz_blank,
  output logic [6:0] seg_out,
  output logic [1:0] dig_en,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] ZERO_PAT = 7'b0111111;
  localparam logic [6:0] SEG_POL = {7{COMMON_ANODE}};
  localparam logic [1:0] DIG_POL = {2{COMMON_ANODE}};

  typedef enum logic [1:0] {
    BLANK_R,
    SHOW_R,
    BLANK_L,
    SHOW_L
  } state_t;

  state_t state;
  state_t stateNext;
  logic [CW-1:0] slotCnt;
  logic [CW-1:0] slotCntNext;
  logic slotEnd;
  logic boundary;
  logic [6:0] pendRight;
  logic [6:0] pendLeft;
  logic pendValid;
  logic [6:0] actRight;
  logic [6:0] actLeft;
  logic actValid;
  logic leftSuppressed;
  logic [6:0] segNext;
  logic [1:0] digNext;

  // Slot sequencing: blank then show for each digit; boundary ends SHOW_L
  always_comb begin
    stateNext = state;
    boundary = 1'b0;
    slotEnd = (slotCnt == SLOT_LAST);
    slotCntNext = slotEnd ? '0 : slotCnt + 1'b1;
    unique case (state)
      BLANK_R: if (slotCnt == BLANK_LAST) stateNext = SHOW_R;
      SHOW_R:  if (slotEnd) stateNext = BLANK_L;
      BLANK_L: if (slotCnt == BLANK_LAST) stateNext = SHOW_L;
      SHOW_L: begin
        if (slotEnd) begin
          stateNext = BLANK_R;
          boundary = 1'b1;
        end
      end
      default: stateNext = BLANK_R;
    endcase
  end

  // Digit decode; nothing lights until a frame has taken real data
  always_comb begin
    segNext = '0;
    digNext = '0;
    leftSuppressed = lz_blank && (actLeft == ZERO_PAT);
    unique case (1'b1)
      (state == SHOW_R) && actValid: begin
        segNext = actRight;
        digNext = 2'b01;
      end
      (state == SHOW_L) && actValid && !leftSuppressed: begin
        segNext = actLeft;
        digNext = 2'b10;
      end
      default: ;
    endcase
  end

  // State register and slot counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK_R;
      slotCnt <= '0;
    end else begin
      state <= stateNext;
      slotCnt <= slotCntNext;
    end
  end

  // Double buffer; a load on the boundary lands in pending after the copy
  always_ff @(posedge clk) begin
    if (rst) begin
      pendRight <= '0;
      pendLeft <= '0;
      pendValid <= 1'b0;
      actRight <= '0;
      actLeft <= '0;
      actValid <= 1'b0;
    end else begin
      if (boundary && pendValid) begin
        actRight <= pendRight;
        actLeft <= pendLeft;
        actValid <= 1'b1;
      end
      if (load) begin
        pendRight <= seg_right;
        pendLeft <= seg_left;
        pendValid <= 1'b1;
      end else if (boundary) begin
        pendValid <= 1'b0;
      end
    end
  end

  // Output register with pin polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= SEG_POL;
      dig_en <= DIG_POL;
      frame_done <= 1'b0;
    end else begin
      seg_out <= segNext ^ SEG_POL;
      dig_en <= digNext ^ DIG_POL;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: scenario tasks plus random traffic checked
// against a frame-position model; a common-anode twin shares all stimulus.
module tb_seven_seg_scan_driver;

  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FR = 2 * RD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic lzBlank = 1'b0;
  logic [6:0] segRight = '0;
  logic [6:0] segLeft = '0;
  logic [6:0] segOut;
  logic [1:0] digEn;
  logic frameDone;
  logic [6:0] segOutCa;
  logic [1:0] digEnCa;
  logic frameDoneCa;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .COMMON_ANODE(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .load(load),
    .seg_right(segRight), .seg_left(segLeft), .lz_blank(lzBlank),
    .seg_out(segOut), .dig_en(digEn), .frame_done(frameDone)
  );

  seven_seg_scan_driver #(
    .REFRESH_DIV(RD), .BLANK_CYCLES(BC), .COMMON_ANODE(1'b1)
  ) dutCa (
    .clk(clk), .rst(rst), .load(load),
    .seg_right(segRight), .seg_left(segLeft), .lz_blank(lzBlank),
    .seg_out(segOutCa), .dig_en(digEnCa), .frame_done(frameDoneCa)
  );

  int nChecks = 0;
  int nFail = 0;

  // model: t = cycles since reset release; frame position = t % FR
  int t = 0;
  logic [6:0] pR, pL, aR, aL;
  bit pv, av;
  logic [6:0] eSeg;
  logic [1:0] eDig;
  logic eFd;

  task automatic tick();
    int p;
    @(posedge clk);
    if (rst) begin
      t = 0;
      pR = '0; pL = '0; aR = '0; aL = '0;
      pv = 0; av = 0;
      eSeg = '0; eDig = '0; eFd = 1'b0;
    end else begin
      p = t % FR;
      eSeg = '0;
      eDig = '0;
      if (av && p >= BC && p < RD) begin
        eSeg = aR; eDig = 2'b01;
      end else if (av && p >= RD + BC && !(lzBlank && aL == 7'h3F)) begin
        eSeg = aL; eDig = 2'b10;
      end
      eFd = (p == FR - 1);
      if (eFd && pv) begin
        aR = pR; aL = pL; av = 1; pv = 0;
      end
      if (load) begin
        pR = segRight; pL = segLeft; pv = 1;
      end
      t++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    nChecks++;
    if (segOut !== 7'h00 || digEn !== 2'b00 || frameDone !== 1'b0 ||
        segOutCa !== 7'h7F || digEnCa !== 2'b11) begin
      nFail++;
      $display("FAIL reset_vals got seg=%h dig=%b fd=%b ca=%h/%b want 00/00/0 7f/11",
               segOut, digEn, frameDone, segOutCa, digEnCa);
    end
    rst = 1'b0;
    repeat (FR) begin
      tick();
      nChecks++;
      if (digEn !== 2'b00 || segOut !== 7'h00 || frameDone !== (t == FR)) begin
        nFail++;
        $display("FAIL first_frame t=%0d got seg=%h dig=%b fd=%b want 00/00/%0d",
                 t, segOut, digEn, frameDone, t == FR);
      end
    end
  endtask

  task automatic test_load_basic();
    repeat (4) tick();
    load = 1'b1; segRight = 7'h06; segLeft = 7'h5B;
    tick();
    load = 1'b0;
    repeat (3 * FR) begin
      tick();
      nChecks++;
      if ({segOut, digEn, frameDone, segOutCa, digEnCa, frameDoneCa} !==
          {eSeg, eDig, eFd, ~eSeg, ~eDig, eFd}) begin
        nFail++;
        $display("FAIL load_basic t=%0d got %h/%b/%b ca %h/%b want %h/%b/%b",
                 t, segOut, digEn, frameDone, segOutCa, digEnCa, eSeg, eDig, eFd);
      end
      if (t > 2 * FR && (t % FR == 5 || t % FR == 13)) begin
        nChecks++;
        if ((t % FR == 5 && {digEn, segOut} !== {2'b01, 7'h06}) ||
            (t % FR == 13 && {digEn, segOut} !== {2'b10, 7'h5B})) begin
          nFail++;
          $display("FAIL load_digits t=%0d got dig=%b seg=%h", t, digEn, segOut);
        end
      end
    end
  endtask

  task automatic test_double_load();
    for (int i = 0; i < FR && t % FR != 1; i++) tick();
    load = 1'b1; segRight = 7'h4F; segLeft = 7'h66;
    tick();
    load = 1'b0;
    repeat (3) tick();
    load = 1'b1; segRight = 7'h6D; segLeft = 7'h7D;
    tick();
    load = 1'b0;
    repeat (2 * FR) begin
      tick();
      nChecks++;
      if ({segOut, digEn, frameDone} !== {eSeg, eDig, eFd} ||
          segOut == 7'h4F || segOut == 7'h66) begin
        nFail++;
        $display("FAIL double_load t=%0d got %h/%b/%b want %h/%b/%b",
                 t, segOut, digEn, frameDone, eSeg, eDig, eFd);
      end
    end
  endtask

  task automatic test_back_to_back_boundary();
    int tb0;
    for (int i = 0; i < FR && t % FR != FR - 1; i++) tick();
    load = 1'b1; segRight = 7'h7F; segLeft = 7'h6F;
    tick();
    load = 1'b0;
    tb0 = t;
    repeat (2 * FR + 2) begin
      tick();
      nChecks++;
      if ({segOut, digEn, frameDone} !== {eSeg, eDig, eFd}) begin
        nFail++;
        $display("FAIL boundary_load t=%0d got %h/%b/%b want %h/%b/%b",
                 t, segOut, digEn, frameDone, eSeg, eDig, eFd);
      end
      if (t == tb0 + 5 || t == tb0 + FR + 5) begin
        nChecks++;
        if (segOut !== ((t == tb0 + 5) ? 7'h6D : 7'h7F) || digEn !== 2'b01) begin
          nFail++;
          $display("FAIL boundary_digit t=%0d got seg=%h dig=%b", t, segOut, digEn);
        end
      end
    end
  endtask

  task automatic test_lz_blank();
    for (int i = 0; i < FR && t % FR != 2; i++) tick();
    load = 1'b1; segRight = 7'h07; segLeft = 7'h3F; lzBlank = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2 * FR && !(t % FR == 13 && t % (2 * FR) >= 0 && i >= FR); i++) begin
        tick();
        nChecks++;
        if ({segOut, digEn, frameDone} !== {eSeg, eDig, eFd}) begin
          nFail++;
          $display("FAIL lz_model t=%0d got %h/%b/%b want %h/%b/%b",
                   t, segOut, digEn, frameDone, eSeg, eDig, eFd);
        end
      end
      nChecks++;
      if ((k == 0 && {digEn, segOut} !== {2'b00, 7'h00}) ||
          (k == 1 && {digEn, segOut} !== {2'b10, 7'h3F})) begin
        nFail++;
        $display("FAIL lz_left lz=%0d t=%0d got dig=%b seg=%h", lzBlank, t, digEn, segOut);
      end
      lzBlank = 1'b0;
    end
  endtask

  task automatic test_reset_ca();
    for (int i = 0; i < FR && t % FR != 12; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nChecks++;
    if (segOutCa !== 7'h7F || digEnCa !== 2'b11 || digEn !== 2'b00) begin
      nFail++;
      $display("FAIL ca_reset got ca seg=%h dig=%b want 7f/11", segOutCa, digEnCa);
    end
    repeat (2 * FR) begin
      tick();
      nChecks++;
      if (segOutCa !== 7'h7F || digEnCa !== 2'b11 || frameDoneCa !== eFd) begin
        nFail++;
        $display("FAIL ca_blank t=%0d got %h/%b/%b want 7f/11/%b",
                 t, segOutCa, digEnCa, frameDoneCa, eFd);
      end
    end
    load = 1'b1; segRight = 7'h06; segLeft = 7'h5B;
    tick();
    load = 1'b0;
    repeat (2 * FR) begin
      tick();
      nChecks++;
      if ({segOutCa, digEnCa, frameDoneCa} !== {~eSeg, ~eDig, eFd}) begin
        nFail++;
        $display("FAIL ca_show t=%0d got %h/%b/%b want %h/%b/%b",
                 t, segOutCa, digEnCa, frameDoneCa, ~eSeg, ~eDig, eFd);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] prevDig;
    prevDig = digEn;
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 9) == 0);
      segRight = 7'($urandom);
      segLeft = ($urandom_range(0, 2) == 0) ? 7'h3F : 7'($urandom);
      if (i % 20 == 0) lzBlank = 1'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      tick();
      nChecks++;
      if ({segOut, digEn, frameDone, segOutCa, digEnCa, frameDoneCa} !==
          {eSeg, eDig, eFd, ~eSeg, ~eDig, eFd} ||
          (prevDig != 2'b00 && digEn != 2'b00 && prevDig != digEn)) begin
        nFail++;
        $display("FAIL random t=%0d got %h/%b/%b ca %h/%b want %h/%b/%b",
                 t, segOut, digEn, frameDone, segOutCa, digEnCa, eSeg, eDig, eFd);
      end
      prevDig = digEn;
    end
    load = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_double_load();
    test_back_to_back_boundary();
    test_lz_blank();
    test_reset_ca();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
